simon_round_key_ram: RTL and testbench
======================================

SIMON_ROUND_KEY_RAM -- requirements
Module: simon_round_key_ram

Interface
REQ-001 SHALL have parameter WORD_W, default 16, round-key word width in bits (legal 16..64).
REQ-002 SHALL have parameter DEPTH, default 32, number of round-key entries (legal 2..128, need not be a power of 2).
REQ-003 SHALL have parameter ADDR_W, default 7, address width; DEPTH <= 2**ADDR_W required.
REQ-004 SHALL have port clk input 1: sole clock, all state updates on its rising edge.
REQ-005 SHALL have port rst_n input 1: asynchronous active-low reset.
REQ-006 SHALL have port clr input 1: one-cycle request to start a clear sweep.
REQ-007 SHALL have port ready output 1: high when the block accepts reads/writes (state IDLE).
REQ-008 SHALL have ports wr_en input 1, wr_addr input ADDR_W, wr_data input WORD_W: write port.
REQ-009 SHALL have ports rd_en input 1, rd_addr input ADDR_W: read request port.
REQ-010 SHALL have ports rd_data output WORD_W, rd_valid output 1, rd_hit output 1: registered read response.
REQ-011 SHALL have port count output ADDR_W+1: number of entries currently marked valid.
REQ-012 SHALL have port full output 1: high when count == DEPTH.
REQ-013 SHALL have port err output 1: one-cycle pulse on a rejected access.

Function
REQ-014 SHALL implement states CLEAR and IDLE; deassertion of rst_n enters CLEAR with sweep pointer 0.
REQ-015 In CLEAR, SHALL write 0 to entry ptr and clear its valid bit each cycle, ptr incrementing 0..DEPTH-1; after ptr==DEPTH-1 next state IDLE (sweep = DEPTH cycles).
REQ-016 clr asserted in IDLE SHALL enter CLEAR with ptr 0 next cycle; clr in CLEAR SHALL restart ptr at 0.
REQ-017 ready SHALL be 1 only in IDLE.
REQ-018 In IDLE, wr_en with wr_addr < DEPTH SHALL write wr_data and set that entry's valid bit at the clock edge.
REQ-019 Read latency SHALL be 1 cycle: rd_en in IDLE with rd_addr < DEPTH gives rd_valid=1 next cycle with rd_data=entry, rd_hit=entry valid bit.
REQ-020 Simultaneous write and read to the same address SHALL be write-first: rd_data = new wr_data, rd_hit = 1.
REQ-021 When rd_valid=0, rd_data SHALL hold its last value and rd_hit SHALL be 0.
REQ-022 count SHALL increment only when a write targets an entry whose valid bit was 0; rewrites leave count unchanged; never exceeds DEPTH.
REQ-023 count SHALL be 0 on the cycle after CLEAR is entered and remain 0 through the sweep.
REQ-024 err SHALL pulse for 1 cycle (next cycle) if: wr_en or rd_en with address >= DEPTH in IDLE, or wr_en or rd_en while not ready; such accesses SHALL have no effect and produce no rd_valid.
REQ-025 A rejected read and a legal write in the same cycle SHALL still perform the write; err pulses once.
REQ-026 clr in IDLE coincident with wr_en/rd_en SHALL take priority: access dropped, err pulses.

Reset
REQ-027 While rst_n=0: ready=0, rd_valid=0, rd_hit=0, rd_data=0, count=0, full=0, err=0, state CLEAR, ptr=0.
REQ-028 Memory contents SHALL be undefined during reset and become 0 only through the post-reset sweep.
REQ-029 Reset asserted mid-sweep or mid-access SHALL abort immediately; no partial write visible after the new sweep.

Verification
REQ-030 Release rst_n, hold idle -> ready=0 for exactly 32 cycles, then ready=1, count=0, full=0.
REQ-031 Write addr 5 = 16'hA5A5, then rd_en addr 5 -> next cycle rd_valid=1, rd_data=16'hA5A5, rd_hit=1; read addr 6 -> rd_data=0, rd_hit=0.
REQ-032 Same cycle wr addr 3 = 16'h1234 and rd addr 3 -> next cycle rd_data=16'h1234, rd_hit=1, count increments by 1.
REQ-033 Write all 32 addresses, rewrite addr 0 -> count=32, full=1 throughout; write addr 40 -> err=1 one cycle, count unchanged.
REQ-034 After fill, pulse clr -> ready=0 for 32 cycles, count=0, every read returns rd_data=0, rd_hit=0; wr_en during sweep -> err=1, no effect.
REQ-035 DEPTH=20, WORD_W=32: rd addr 20 -> err=1, no rd_valid; rst_n low at sweep ptr 10 -> sweep restarts, ready after 20 cycles.

Source files
------------

// File: rtl/simon_round_key_ram.sv
// Round-key storage for a SIMON key schedule: a DEPTH-entry word RAM with per-entry
// valid bits, a hardware clear sweep, registered single-cycle reads and access checking.
module simon_round_key_ram #(
   parameter int WORD_W = 16,
   parameter int DEPTH  = 32,
   parameter int ADDR_W = 7
) (
   input  logic              clk,
   input  logic              rst_n,
   input  logic              clr,
   output logic              ready,
   input  logic              wr_en,
   input  logic [ADDR_W-1:0] wr_addr,
   input  logic [WORD_W-1:0] wr_data,
   input  logic              rd_en,
   input  logic [ADDR_W-1:0] rd_addr,
   output logic [WORD_W-1:0] rd_data,
   output logic              rd_valid,
   output logic              rd_hit,
   output logic [ADDR_W:0]   count,
   output logic              full,
   output logic              err
);

   localparam int                IDX_W    = (DEPTH > 1) ? $clog2(DEPTH) : 1;
   localparam logic [ADDR_W:0]   DEPTH_L  = (ADDR_W + 1)'(DEPTH);
   localparam logic [IDX_W-1:0]  LAST_IDX = IDX_W'(DEPTH - 1);

   typedef enum logic {
      CLEAR,
      IDLE
   } state_t;

   state_t             state;
   logic [IDX_W-1:0]   ptr;
   logic [WORD_W-1:0]  mem [DEPTH];
   logic [DEPTH-1:0]   valid;

   logic               idle;
   logic               accept;
   logic               wr_in_range;
   logic               rd_in_range;
   logic               wr_do;
   logic               rd_do;
   logic               reject;
   logic               bypass;
   logic [IDX_W-1:0]   wr_idx;
   logic [IDX_W-1:0]   rd_idx;

   assign idle        = (state == IDLE);
   assign accept      = idle && !clr;
   assign wr_in_range = ({1'b0, wr_addr} < DEPTH_L);
   assign rd_in_range = ({1'b0, rd_addr} < DEPTH_L);
   assign wr_idx      = wr_addr[IDX_W-1:0];
   assign rd_idx      = rd_addr[IDX_W-1:0];
   assign wr_do       = accept && wr_en && wr_in_range;
   assign rd_do       = accept && rd_en && rd_in_range;
   assign bypass      = wr_do && (wr_addr == rd_addr);

   // Any access that cannot be honoured (busy, clr wins, or out of range) flags an error;
   // a legal half of a mixed request still goes ahead.
   assign reject = (wr_en || rd_en) &&
                   (!idle || clr || (wr_en && !wr_in_range) || (rd_en && !rd_in_range));

   assign ready = idle;
   assign full  = (count == DEPTH_L);

   // Control state, valid bits, occupancy and the registered read response.
   always_ff @(posedge clk or negedge rst_n) begin
      if (!rst_n) begin
         state    <= CLEAR;
         ptr      <= '0;
         valid    <= '0;
         count    <= '0;
         rd_data  <= '0;
         rd_valid <= 1'b0;
         rd_hit   <= 1'b0;
         err      <= 1'b0;
      end else begin
         err      <= reject;
         rd_valid <= rd_do;
         rd_hit   <= 1'b0;
         if (rd_do) begin
            rd_data <= bypass ? wr_data : mem[rd_idx];
            rd_hit  <= bypass | valid[rd_idx];
         end
         case (state)
            CLEAR: begin
               count      <= '0;
               valid[ptr] <= 1'b0;
               if (clr) begin
                  ptr <= '0;
               end else if (ptr == LAST_IDX) begin
                  ptr   <= '0;
                  state <= IDLE;
               end else begin
                  ptr <= ptr + 1'b1;
               end
            end
            IDLE: begin
               if (clr) begin
                  state <= CLEAR;
                  ptr   <= '0;
                  count <= '0;
               end else if (wr_do) begin
                  valid[wr_idx] <= 1'b1;
                  if (!valid[wr_idx]) begin
                     count <= count + 1'b1;
                  end
               end
            end
            default: begin
               state <= CLEAR;
               ptr   <= '0;
            end
         endcase
      end
   end

   // Storage array is left unreset so it maps onto RAM; the sweep is what zeroes it.
   always_ff @(posedge clk) begin
      if (state == CLEAR) begin
         mem[ptr] <= '0;
      end else if (wr_do) begin
         mem[wr_idx] <= wr_data;
      end
   end

endmodule

// File: tb/tb_simon_round_key_ram.sv
// Directed bench for simon_round_key_ram: default 32x16 instance plus a 20x32 instance.
module tb_simon_round_key_ram;

   logic        clk;
   logic        rst_n, clr, wr_en, rd_en;
   logic [6:0]  wr_addr, rd_addr;
   logic [15:0] wr_data, rd_data;
   logic        ready, rd_valid, rd_hit, full, err;
   logic [7:0]  count;

   logic        rst_n20, clr20, wr_en20, rd_en20;
   logic [6:0]  wr_addr20, rd_addr20;
   logic [31:0] wr_data20, rd_data20;
   logic        ready20, rd_valid20, rd_hit20, full20, err20;
   logic [7:0]  count20;

   int checks = 0;
   int failures = 0;

   simon_round_key_ram dut (
      .clk(clk), .rst_n(rst_n), .clr(clr), .ready(ready),
      .wr_en(wr_en), .wr_addr(wr_addr), .wr_data(wr_data),
      .rd_en(rd_en), .rd_addr(rd_addr),
      .rd_data(rd_data), .rd_valid(rd_valid), .rd_hit(rd_hit),
      .count(count), .full(full), .err(err)
   );

   simon_round_key_ram #(.WORD_W(32), .DEPTH(20), .ADDR_W(7)) dut20 (
      .clk(clk), .rst_n(rst_n20), .clr(clr20), .ready(ready20),
      .wr_en(wr_en20), .wr_addr(wr_addr20), .wr_data(wr_data20),
      .rd_en(rd_en20), .rd_addr(rd_addr20),
      .rd_data(rd_data20), .rd_valid(rd_valid20), .rd_hit(rd_hit20),
      .count(count20), .full(full20), .err(err20)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   task automatic test_reset;
      int cnt;
      repeat (3) @(negedge clk);
      checks++; if (ready !== 1'b0) begin failures++; $display("[TB] FAIL reset_ready got=%0h exp=0", ready); end
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_valid got=%0h exp=0", rd_valid); end
      checks++; if (rd_hit !== 1'b0) begin failures++; $display("[TB] FAIL reset_rd_hit got=%0h exp=0", rd_hit); end
      checks++; if (rd_data !== 16'h0) begin failures++; $display("[TB] FAIL reset_rd_data got=%0h exp=0", rd_data); end
      checks++; if (count !== 8'd0) begin failures++; $display("[TB] FAIL reset_count got=%0d exp=0", count); end
      checks++; if (full !== 1'b0) begin failures++; $display("[TB] FAIL reset_full got=%0h exp=0", full); end
      checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL reset_err got=%0h exp=0", err); end
      rst_n = 1'b1;
      cnt = 0;
      while (!ready && cnt < 200) begin cnt++; @(negedge clk); end
      checks++; if (cnt !== 32) begin failures++; $display("[TB] FAIL reset_sweep_cycles got=%0d exp=32", cnt); end
      checks++; if (count !== 8'd0) begin failures++; $display("[TB] FAIL post_sweep_count got=%0d exp=0", count); end
      checks++; if (full !== 1'b0) begin failures++; $display("[TB] FAIL post_sweep_full got=%0h exp=0", full); end
   endtask

   task automatic test_write_read;
      wr_en = 1'b1; wr_addr = 7'd5; wr_data = 16'hA5A5;
      @(negedge clk);
      wr_en = 1'b0;
      checks++; if (count !== 8'd1) begin failures++; $display("[TB] FAIL wr5_count got=%0d exp=1", count); end
      rd_en = 1'b1; rd_addr = 7'd5;
      @(negedge clk);
      rd_en = 1'b0;
      checks++; if (rd_valid !== 1'b1) begin failures++; $display("[TB] FAIL rd5_valid got=%0h exp=1", rd_valid); end
      checks++; if (rd_data !== 16'hA5A5) begin failures++; $display("[TB] FAIL rd5_data got=%0h exp=a5a5", rd_data); end
      checks++; if (rd_hit !== 1'b1) begin failures++; $display("[TB] FAIL rd5_hit got=%0h exp=1", rd_hit); end
      @(negedge clk);
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL idle_valid got=%0h exp=0", rd_valid); end
      checks++; if (rd_hit !== 1'b0) begin failures++; $display("[TB] FAIL idle_hit got=%0h exp=0", rd_hit); end
      checks++; if (rd_data !== 16'hA5A5) begin failures++; $display("[TB] FAIL idle_hold got=%0h exp=a5a5", rd_data); end
      rd_en = 1'b1; rd_addr = 7'd6;
      @(negedge clk);
      rd_en = 1'b0;
      checks++; if (rd_valid !== 1'b1) begin failures++; $display("[TB] FAIL rd6_valid got=%0h exp=1", rd_valid); end
      checks++; if (rd_data !== 16'h0) begin failures++; $display("[TB] FAIL rd6_data got=%0h exp=0", rd_data); end
      checks++; if (rd_hit !== 1'b0) begin failures++; $display("[TB] FAIL rd6_hit got=%0h exp=0", rd_hit); end
   endtask

   task automatic test_write_first;
      wr_en = 1'b1; wr_addr = 7'd3; wr_data = 16'h1234;
      rd_en = 1'b1; rd_addr = 7'd3;
      @(negedge clk);
      wr_en = 1'b0; rd_en = 1'b0;
      checks++; if (rd_valid !== 1'b1) begin failures++; $display("[TB] FAIL wf_valid got=%0h exp=1", rd_valid); end
      checks++; if (rd_data !== 16'h1234) begin failures++; $display("[TB] FAIL wf_data got=%0h exp=1234", rd_data); end
      checks++; if (rd_hit !== 1'b1) begin failures++; $display("[TB] FAIL wf_hit got=%0h exp=1", rd_hit); end
      checks++; if (count !== 8'd2) begin failures++; $display("[TB] FAIL wf_count got=%0d exp=2", count); end
   endtask

   task automatic test_fill;
      for (int i = 0; i < 32; i++) begin
         wr_en = 1'b1; wr_addr = 7'(i); wr_data = 16'h0100 + 16'(i);
         @(negedge clk);
      end
      wr_en = 1'b0;
      checks++; if (count !== 8'd32) begin failures++; $display("[TB] FAIL fill_count got=%0d exp=32", count); end
      checks++; if (full !== 1'b1) begin failures++; $display("[TB] FAIL fill_full got=%0h exp=1", full); end
      wr_en = 1'b1; wr_addr = 7'd0; wr_data = 16'hFFFF;
      @(negedge clk);
      wr_en = 1'b0;
      checks++; if (count !== 8'd32) begin failures++; $display("[TB] FAIL rewrite_count got=%0d exp=32", count); end
      checks++; if (full !== 1'b1) begin failures++; $display("[TB] FAIL rewrite_full got=%0h exp=1", full); end
      wr_en = 1'b1; wr_addr = 7'd40; wr_data = 16'h4040;
      @(negedge clk);
      wr_en = 1'b0;
      checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL wr40_err got=%0h exp=1", err); end
      checks++; if (count !== 8'd32) begin failures++; $display("[TB] FAIL wr40_count got=%0d exp=32", count); end
      @(negedge clk);
      checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL wr40_err_pulse got=%0h exp=0", err); end
      rd_en = 1'b1; rd_addr = 7'd0;
      @(negedge clk);
      checks++; if (rd_data !== 16'hFFFF) begin failures++; $display("[TB] FAIL rd0_data got=%0h exp=ffff", rd_data); end
      rd_addr = 7'd31;
      @(negedge clk);
      rd_en = 1'b0;
      checks++; if (rd_data !== 16'h011F) begin failures++; $display("[TB] FAIL rd31_data got=%0h exp=11f", rd_data); end
      rd_en = 1'b1; rd_addr = 7'd50;
      wr_en = 1'b1; wr_addr = 7'd4; wr_data = 16'hBEEF;
      @(negedge clk);
      rd_en = 1'b0; wr_en = 1'b0;
      checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL mixed_err got=%0h exp=1", err); end
      checks++; if (rd_valid !== 1'b0) begin failures++; $display("[TB] FAIL mixed_rd_valid got=%0h exp=0", rd_valid); end
      rd_en = 1'b1; rd_addr = 7'd4;
      @(negedge clk);
      rd_en = 1'b0;
      checks++; if (err !== 1'b0) begin failures++; $display("[TB] FAIL mixed_err_pulse got=%0h exp=0", err); end
      checks++; if (rd_data !== 16'hBEEF) begin failures++; $display("[TB] FAIL mixed_wr_data got=%0h exp=beef", rd_data); end
      checks++; if (rd_hit !== 1'b1) begin failures++; $display("[TB] FAIL mixed_wr_hit got=%0h exp=1", rd_hit); end
   endtask

   task automatic test_clear;
      int cnt;
      clr = 1'b1; wr_en = 1'b1; wr_addr = 7'd1; wr_data = 16'h7777;
      @(negedge clk);
      clr = 1'b0; wr_en = 1'b0;
      checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL clr_prio_err got=%0h exp=1", err); end
      checks++; if (ready !== 1'b0) begin failures++; $display("[TB] FAIL clr_ready got=%0h exp=0", ready); end
      checks++; if (count !== 8'd0) begin failures++; $display("[TB] FAIL clr_count got=%0d exp=0", count); end
      checks++; if (full !== 1'b0) begin failures++; $display("[TB] FAIL clr_full got=%0h exp=0", full); end
      cnt = 1;
      wr_en = 1'b1; wr_addr = 7'd2; wr_data = 16'h2222;
      @(negedge clk);
      wr_en = 1'b0;
      checks++; if (err !== 1'b1) begin failures++; $display("[TB] FAIL sweep_wr_err got=%0h exp=1", err); end
      checks++; if (count !== 8'd0) begin failures++; $display("[TB] FAIL sweep_wr_count got=%0d exp=0", count); end
      while (!ready && cnt < 200) begin cnt++; @(negedge clk); end
      checks++; if (cnt !== 32) begin failures++; $display("[TB] FAIL clr_sweep_cycles got=%0d exp=32", cnt); end
      checks++; if (count !== 8'd0) begin failures++; $display("[TB] FAIL clr_done_count got=%0d exp=0", count); end
      for (int i = 0; i < 4; i++) begin
         rd_en = 1'b1;
         rd_addr = (i == 3) ? 7'd31 : 7'(i);
         @(negedge clk);
         checks++; if (rd_valid !== 1'b1) begin failures++; $display("[TB] FAIL clr_rd_valid a=%0d got=%0h exp=1", rd_addr, rd_valid); end
         checks++; if (rd_data !== 16'h0) begin failures++; $display("[TB] FAIL clr_rd_data a=%0d got=%0h exp=0", rd_addr, rd_data); end
         checks++; if (rd_hit !== 1'b0) begin failures++; $display("[TB] FAIL clr_rd_hit a=%0d got=%0h exp=0", rd_addr, rd_hit); end
      end
      rd_en = 1'b0;
   endtask

   task automatic test_depth20;
      int cnt;
      checks++; if (ready20 !== 1'b0) begin failures++; $display("[TB] FAIL d20_reset_ready got=%0h exp=0", ready20); end
      checks++; if (rd_data20 !== 32'h0) begin failures++; $display("[TB] FAIL d20_reset_rd_data got=%0h exp=0", rd_data20); end
      rst_n20 = 1'b1;
      cnt = 0;
      while (!ready20 && cnt < 200) begin cnt++; @(negedge clk); end
      checks++; if (cnt !== 20) begin failures++; $display("[TB] FAIL d20_sweep_cycles got=%0d exp=20", cnt); end
      rd_en20 = 1'b1; rd_addr20 = 7'd20;
      @(negedge clk);
      rd_en20 = 1'b0;
      checks++; if (err20 !== 1'b1) begin failures++; $display("[TB] FAIL d20_rd20_err got=%0h exp=1", err20); end
      checks++; if (rd_valid20 !== 1'b0) begin failures++; $display("[TB] FAIL d20_rd20_valid got=%0h exp=0", rd_valid20); end
      wr_en20 = 1'b1; wr_addr20 = 7'd19; wr_data20 = 32'hDEADBEEF;
      @(negedge clk);
      wr_en20 = 1'b0;
      rd_en20 = 1'b1; rd_addr20 = 7'd19;
      @(negedge clk);
      rd_en20 = 1'b0;
      checks++; if (rd_data20 !== 32'hDEADBEEF) begin failures++; $display("[TB] FAIL d20_rd19_data got=%0h exp=deadbeef", rd_data20); end
      checks++; if (rd_hit20 !== 1'b1) begin failures++; $display("[TB] FAIL d20_rd19_hit got=%0h exp=1", rd_hit20); end
      checks++; if (count20 !== 8'd1) begin failures++; $display("[TB] FAIL d20_count got=%0d exp=1", count20); end
   endtask

   task automatic test_reset_midsweep;
      int cnt;
      wr_en20 = 1'b1; wr_addr20 = 7'd5; wr_data20 = 32'h11111111;
      #2;
      rst_n20 = 1'b0;
      wr_en20 = 1'b0;
      #1;
      checks++; if (count20 !== 8'd0) begin failures++; $display("[TB] FAIL d20_rst_count got=%0d exp=0", count20); end
      checks++; if (rd_data20 !== 32'h0) begin failures++; $display("[TB] FAIL d20_rst_rd_data got=%0h exp=0", rd_data20); end
      @(negedge clk);
      rst_n20 = 1'b1;
      repeat (10) @(negedge clk);
      rst_n20 = 1'b0;
      #1;
      checks++; if (ready20 !== 1'b0) begin failures++; $display("[TB] FAIL d20_mid_ready got=%0h exp=0", ready20); end
      @(negedge clk);
      rst_n20 = 1'b1;
      cnt = 0;
      while (!ready20 && cnt < 200) begin cnt++; @(negedge clk); end
      checks++; if (cnt !== 20) begin failures++; $display("[TB] FAIL d20_restart_cycles got=%0d exp=20", cnt); end
      for (int i = 0; i < 2; i++) begin
         rd_en20 = 1'b1;
         rd_addr20 = (i == 0) ? 7'd5 : 7'd19;
         @(negedge clk);
         checks++; if (rd_data20 !== 32'h0) begin failures++; $display("[TB] FAIL d20_after_rd_data a=%0d got=%0h exp=0", rd_addr20, rd_data20); end
         checks++; if (rd_hit20 !== 1'b0) begin failures++; $display("[TB] FAIL d20_after_rd_hit a=%0d got=%0h exp=0", rd_addr20, rd_hit20); end
      end
      rd_en20 = 1'b0;
   endtask

   initial begin
      rst_n = 1'b0; clr = 1'b0; wr_en = 1'b0; rd_en = 1'b0;
      wr_addr = '0; rd_addr = '0; wr_data = '0;
      rst_n20 = 1'b0; clr20 = 1'b0; wr_en20 = 1'b0; rd_en20 = 1'b0;
      wr_addr20 = '0; rd_addr20 = '0; wr_data20 = '0;
      test_reset();
      test_write_read();
      test_write_first();
      test_fill();
      test_clear();
      test_depth20();
      test_reset_midsweep();
      $display("End of test - %0d assertions evaluated, %0d failures", checks, failures);
      $finish;
   end

endmodule
